// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine.
//   state_t        : engine FSM states
//   MAX_BYTES      : largest transfer the engine accepts
//   CSR_*          : bit positions of the SPI control/status register fields
//   byte_swap32    : reorders a word so byte 0 sits in the MSBs (serial order)
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int MAX_BYTES = 4;

    localparam int CSR_CPOL_BIT                    = 0;
    localparam int CSR_CPHA_BIT                    = 1;
    localparam int CSR_WDATA_VALID_BYTES_LSB       = 4;
    localparam int CSR_WDATA_VALID_BYTES_MSB       = 6;
    localparam int CSR_RDATA_BYTES_VALID_COUNT_LSB = 8;
    localparam int CSR_RDATA_BYTES_VALID_COUNT_MSB = 10;

    function automatic logic [31:0] byte_swap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCK divider for the SPI shift engine.
//   clk_i, rst_i  : system clock, synchronous active-high reset
//   enable_i      : run the divider (high only while shifting)
//   cpol_i        : SCK idle level
//   lead_stb_o    : one-cycle pulse; SCK takes its leading edge at this clock edge
//   trail_stb_o   : one-cycle pulse; SCK takes its trailing edge at this clock edge
//   sck_o         : SCK level
module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic enable_i,
    input  logic cpol_i,
    output logic lead_stb_o,
    output logic trail_stb_o,
    output logic sck_o
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             phase_q, phase_d;   // 1 while SCK is at its active level
    logic             tc;

    assign tc = enable_i && (div_cnt_q == CNT_W'(1));

    always_comb begin
        div_cnt_d = div_cnt_q;
        phase_d   = phase_q;
        if (!enable_i) begin
            div_cnt_d = DIV_LOAD;
            phase_d   = 1'b0;
        end else if (tc) begin
            div_cnt_d = DIV_LOAD;
            phase_d   = ~phase_q;
        end else begin
            div_cnt_d = div_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_cnt_q <= DIV_LOAD;
            phase_q   <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
        end
    end

    assign lead_stb_o  = tc & ~phase_q;
    assign trail_stb_o = tc &  phase_q;
    assign sck_o       = cpol_i ^ phase_q;

endmodule

// File: rtl/spi_shift_engine.sv
// Bit-level SPI shift engine: serialises 1..4 bytes of tx_data_i onto MOSI
// (byte 0 first, MSB first) and captures MISO into rx_data_o.
//   clk_i, rst_i       : system clock, synchronous active-high reset
//   start_i            : transfer request (honoured only in IDLE)
//   cpol_i, cpha_i     : SPI mode, latched at accepted start
//   tx_data_i          : write word, latched at accepted start
//   tx_bytes_i         : byte count 1..4; other values ignore the start
//   clear_rx_i         : zero rx_bytes_valid_o
//   busy_o, done_o     : in-transfer flag, one-cycle completion pulse
//   rx_data_o          : received bytes, byte k in bits [8k+7:8k]
//   rx_bytes_valid_o   : bytes captured since last start/clear
//   spi_clk_o, spi_mosi_o, spi_miso_i : SPI pins
//
// state | meaning
// IDLE  | waiting for a valid start; MOSI low, SCK at latched CPOL
// SHIFT | 16*N SCK edges being generated, data shifted/sampled
// DONE  | single cycle, done_o asserted
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        cpol_i,
    input  logic        cpha_i,
    input  logic [31:0] tx_data_i,
    input  logic [2:0]  tx_bytes_i,
    input  logic        clear_rx_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rx_data_o,
    output logic [2:0]  rx_bytes_valid_o,
    output logic        spi_clk_o,
    output logic        spi_mosi_o,
    input  logic        spi_miso_i
);

    state_t      state_q, state_d;
    logic        cpol_q, cpol_d;
    logic        cpha_q, cpha_d;
    logic [31:0] tx_sr_q, tx_sr_d;
    logic        mosi_q, mosi_d;
    logic [6:0]  edge_cnt_q, edge_cnt_d;   // SCK edges still to generate
    logic [6:0]  rx_byte_q, rx_byte_d;     // first seven bits of the byte in flight
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [1:0]  rx_idx_q, rx_idx_d;       // not touched by clear_rx_i
    logic [31:0] rx_data_q, rx_data_d;
    logic [2:0]  rx_cnt_q, rx_cnt_d;

    logic lead_stb, trail_stb;
    logic sample_stb, shift_stb;
    logic accept, byte_done;
    logic [31:0] tx_serial;

    spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .enable_i    (state_q == SHIFT),
        .cpol_i      (cpol_q),
        .lead_stb_o  (lead_stb),
        .trail_stb_o (trail_stb),
        .sck_o       (spi_clk_o)
    );

    assign sample_stb = cpha_q ? trail_stb : lead_stb;
    assign shift_stb  = cpha_q ? lead_stb  : trail_stb;
    assign tx_serial  = byte_swap32(tx_data_i);

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        tx_sr_d    = tx_sr_q;
        mosi_d     = mosi_q;
        edge_cnt_d = edge_cnt_q;
        rx_byte_d  = rx_byte_q;
        rx_bit_d   = rx_bit_q;
        rx_idx_d   = rx_idx_q;
        rx_data_d  = rx_data_q;
        accept     = 1'b0;
        byte_done  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && tx_bytes_i != 3'd0 && tx_bytes_i <= 3'(MAX_BYTES)) begin
                    accept     = 1'b1;
                    state_d    = SHIFT;
                    cpol_d     = cpol_i;
                    cpha_d     = cpha_i;
                    edge_cnt_d = {tx_bytes_i, 4'b0000};
                    rx_byte_d  = '0;
                    rx_bit_d   = '0;
                    rx_idx_d   = '0;
                    rx_data_d  = '0;
                    // CPHA=0 must present the first bit before the first edge;
                    // CPHA=1 puts it out on the first (leading) edge instead.
                    if (!cpha_i) begin
                        mosi_d  = tx_serial[31];
                        tx_sr_d = tx_serial << 1;
                    end else begin
                        mosi_d  = 1'b0;
                        tx_sr_d = tx_serial;
                    end
                end
            end
            SHIFT: begin
                if (lead_stb || trail_stb) begin
                    edge_cnt_d = edge_cnt_q - 7'd1;
                    if (edge_cnt_q == 7'd1) begin
                        state_d = DONE;
                    end
                end
                if (shift_stb) begin
                    mosi_d  = tx_sr_q[31];
                    tx_sr_d = tx_sr_q << 1;
                end
                if (sample_stb) begin
                    rx_byte_d = {rx_byte_q[5:0], spi_miso_i};
                    rx_bit_d  = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        byte_done = 1'b1;
                        rx_data_d[{rx_idx_q, 3'b000} +: 8] = {rx_byte_q, spi_miso_i};
                        rx_idx_d  = rx_idx_q + 2'd1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                mosi_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                mosi_d  = 1'b0;
            end
        endcase

        // A clear landing on a byte completion keeps that byte counted.
        rx_cnt_d = rx_cnt_q;
        if (accept) begin
            rx_cnt_d = '0;
        end else if (clear_rx_i) begin
            rx_cnt_d = byte_done ? 3'd1 : 3'd0;
        end else if (byte_done) begin
            rx_cnt_d = rx_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sr_q    <= '0;
            mosi_q     <= 1'b0;
            edge_cnt_q <= '0;
            rx_byte_q  <= '0;
            rx_bit_q   <= '0;
            rx_idx_q   <= '0;
            rx_data_q  <= '0;
            rx_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            tx_sr_q    <= tx_sr_d;
            mosi_q     <= mosi_d;
            edge_cnt_q <= edge_cnt_d;
            rx_byte_q  <= rx_byte_d;
            rx_bit_q   <= rx_bit_d;
            rx_idx_q   <= rx_idx_d;
            rx_data_q  <= rx_data_d;
            rx_cnt_q   <= rx_cnt_d;
        end
    end

    assign busy_o           = (state_q == SHIFT);
    assign done_o           = (state_q == DONE);
    assign rx_data_o        = rx_data_q;
    assign rx_bytes_valid_o = rx_cnt_q;
    assign spi_mosi_o       = (state_q == SHIFT) & mosi_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: two instances (CLK_DIV=1 and 2),
// a table of transfers plus hand sequences for invalid starts, clear/complete
// collision, mid-transfer reset and a held start.
module tb_spi_shift_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start1, start2;
    logic        cpol, cpha, clear_rx;
    logic [31:0] txd;
    logic [2:0]  txb;
    int          miso_mode;     // 0: tied low, 1: tied high, 2: looped to MOSI
    int          sel;           // which instance the monitor watches

    logic        busy1, done1, sck1, mosi1, miso1;
    logic [31:0] rxd1;
    logic [2:0]  rxc1;
    logic        busy2, done2, sck2, mosi2, miso2;
    logic [31:0] rxd2;
    logic [2:0]  rxc2;

    logic        busy_m, done_m, sck_m, mosi_m;
    logic [31:0] rxd_m;
    logic [2:0]  rxc_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign miso1 = (miso_mode == 2) ? mosi1 : (miso_mode == 1);
    assign miso2 = (miso_mode == 2) ? mosi2 : (miso_mode == 1);

    spi_shift_engine #(.CLK_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .cpol_i(cpol), .cpha_i(cpha),
        .tx_data_i(txd), .tx_bytes_i(txb), .clear_rx_i(clear_rx),
        .busy_o(busy1), .done_o(done1), .rx_data_o(rxd1), .rx_bytes_valid_o(rxc1),
        .spi_clk_o(sck1), .spi_mosi_o(mosi1), .spi_miso_i(miso1)
    );

    spi_shift_engine #(.CLK_DIV(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .cpol_i(cpol), .cpha_i(cpha),
        .tx_data_i(txd), .tx_bytes_i(txb), .clear_rx_i(clear_rx),
        .busy_o(busy2), .done_o(done2), .rx_data_o(rxd2), .rx_bytes_valid_o(rxc2),
        .spi_clk_o(sck2), .spi_mosi_o(mosi2), .spi_miso_i(miso2)
    );

    always_comb begin
        if (sel == 2) begin
            busy_m = busy2; done_m = done2; sck_m = sck2; mosi_m = mosi2;
            rxd_m  = rxd2;  rxc_m  = rxc2;
        end else begin
            busy_m = busy1; done_m = done1; sck_m = sck1; mosi_m = mosi1;
            rxd_m  = rxd1;  rxc_m  = rxc1;
        end
    end

    typedef struct {
        int          sel;
        logic        cpol;
        logic        cpha;
        logic [31:0] data;
        logic [2:0]  nbytes;
        int          miso_mode;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_start(input int s, input logic v);
        if (s == 2) start2 = v;
        else        start1 = v;
    endtask

    // One complete transfer with timing, SCK, MOSI and RX checks.
    // Returns at the negedge of the cycle after DONE (start left high if hold).
    task automatic run_xfer(input string tag, input int s, input logic p, input logic h,
                            input logic [31:0] data, input logic [2:0] nb, input int mm,
                            input logic [31:0] exp_rx, input bit hold);
        int          cdiv, n, done_k, busy_n, edges, nbits, steps;
        logic [31:0] cap, ser;
        logic        prev_sck, prev_mosi;
        logic [2:0]  prev_cnt;
        cdiv = (s == 2) ? 2 : 1;
        n    = int'(nb);
        ser  = '0;
        for (int b = 0; b < n; b++) ser = (ser << 8) | ((data >> (8 * b)) & 32'hFF);

        @(negedge clk);
        sel = s; miso_mode = mm; cpol = p; cpha = h; txd = data; txb = nb;
        set_start(s, 1'b1);
        @(negedge clk);
        if (!hold) set_start(s, 1'b0);
        check({tag, "_sck_idle_start"}, 32'(sck_m), 32'(p));

        prev_sck = sck_m; prev_mosi = mosi_m; prev_cnt = rxc_m;
        done_k = 0; busy_n = 0; edges = 0; nbits = 0; steps = 0; cap = '0;
        for (int k = 1; k <= 200; k++) begin
            if (sck_m !== prev_sck) begin
                edges++;
                if ((h == 1'b0 && sck_m != p) || (h == 1'b1 && sck_m == p)) begin
                    cap = {cap[30:0], prev_mosi};
                    nbits++;
                end
            end
            if (rxc_m != prev_cnt) begin
                if (rxc_m == prev_cnt + 3'd1) steps++;
                else steps += 100;
            end
            prev_sck = sck_m; prev_mosi = mosi_m; prev_cnt = rxc_m;
            if (done_m) begin
                done_k = k;
                break;
            end
            if (busy_m) busy_n++;
            @(negedge clk);
        end
        check({tag, "_done_cycle"}, 32'(done_k), 32'(16 * n * cdiv + 1));
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'(16 * n * cdiv));
        check({tag, "_busy_in_done"}, 32'(busy_m), 32'd0);
        check({tag, "_sck_edges"}, 32'(edges), 32'(16 * n));
        check({tag, "_mosi_nbits"}, 32'(nbits), 32'(8 * n));
        check({tag, "_mosi_bits"}, cap, ser);
        check({tag, "_rx_data"}, rxd_m, exp_rx);
        check({tag, "_rx_count"}, 32'(rxc_m), 32'(n));
        check({tag, "_rx_steps"}, 32'(steps), 32'(n));
        check({tag, "_sck_idle_done"}, 32'(sck_m), 32'(p));
        @(negedge clk);
        check({tag, "_done_pulse_end"}, 32'(done_m), 32'd0);
        check({tag, "_busy_after"}, 32'(busy_m), 32'd0);
    endtask

    // Start with an illegal byte count; nothing may move.
    task automatic invalid_start(input string tag, input logic [2:0] nb);
        logic [2:0]  cnt0;
        logic [31:0] rx0;
        logic        sck0;
        int          busy_seen, done_seen, sck_moves;
        sel = 1;
        @(negedge clk);
        cnt0 = rxc1; rx0 = rxd1; sck0 = sck1;
        txb = nb; cpol = 1'b1; cpha = 1'b0; start1 = 1'b1;
        busy_seen = 0; done_seen = 0; sck_moves = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2) start1 = 1'b0;
            if (busy1) busy_seen++;
            if (done1) done_seen++;
            if (sck1 !== sck0) sck_moves++;
        end
        check({tag, "_busy"}, 32'(busy_seen), 32'd0);
        check({tag, "_done"}, 32'(done_seen), 32'd0);
        check({tag, "_sck_static"}, 32'(sck_moves), 32'd0);
        check({tag, "_rx_count_kept"}, 32'(rxc1), 32'(cnt0));
        check({tag, "_rx_data_kept"}, rxd1, rx0);
    endtask

    int done_k;
    int busy_seen, done_seen, sck_moves;

    initial begin
        vecs[0] = '{2, 1'b0, 1'b0, 32'h0000_00A5, 3'd1, 2, 32'h0000_00A5};
        vecs[1] = '{1, 1'b1, 1'b1, 32'h1122_3344, 3'd4, 1, 32'hFFFF_FFFF};
        vecs[2] = '{1, 1'b0, 1'b1, 32'hDEAD_BEEF, 3'd3, 2, 32'h00AD_BEEF};
        vecs[3] = '{2, 1'b1, 1'b0, 32'h0000_C35A, 3'd2, 0, 32'h0000_0000};
        vecs[4] = '{1, 1'b0, 1'b0, 32'h8000_0001, 3'd4, 2, 32'h8000_0001};

        rst = 1'b1; start1 = 1'b0; start2 = 1'b0; cpol = 1'b1; cpha = 1'b1;
        clear_rx = 1'b0; txd = 32'hFFFF_FFFF; txb = 3'd4; miso_mode = 1; sel = 1;
        repeat (3) @(negedge clk);
        check("rst_busy",  32'({busy1, busy2}), 32'd0);
        check("rst_done",  32'({done1, done2}), 32'd0);
        check("rst_rxd1",  rxd1, 32'd0);
        check("rst_rxd2",  rxd2, 32'd0);
        check("rst_rxc",   32'({rxc1, rxc2}), 32'd0);
        check("rst_sck",   32'({sck1, sck2}), 32'd0);
        check("rst_mosi",  32'({mosi1, mosi2}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].sel, vecs[i].cpol, vecs[i].cpha,
                     vecs[i].data, vecs[i].nbytes, vecs[i].miso_mode, vecs[i].exp_rx, 1'b0);
        end

        invalid_start("bytes0", 3'd0);
        invalid_start("bytes5", 3'd5);

        // Clear in IDLE: count drops, data kept.
        sel = 1;
        @(negedge clk);
        clear_rx = 1'b1;
        @(negedge clk);
        clear_rx = 1'b0;
        check("idle_clear_count", 32'(rxc1), 32'd0);
        check("idle_clear_data", rxd1, 32'h8000_0001);

        // clear_rx_i on the cycle byte 2 completes (CLK_DIV=1, mode 0:
        // bit 0 of byte 1 is sampled on edge 31, end of SHIFT cycle 31).
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; txd = 32'h00CC_BBAA; txb = 3'd3; miso_mode = 2;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (30) @(negedge clk);
        check("coll_pre_count", 32'(rxc1), 32'd1);
        clear_rx = 1'b1;
        @(negedge clk);
        clear_rx = 1'b0;
        check("coll_count", 32'(rxc1), 32'd1);
        check("coll_data", rxd1, 32'h0000_BBAA);
        done_k = 0;
        for (int k = 32; k <= 80; k++) begin
            if (done1) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
        check("coll_done_cycle", 32'(done_k), 32'd49);
        check("coll_final_count", 32'(rxc1), 32'd2);
        check("coll_final_data", rxd1, 32'h00CC_BBAA);

        // Reset in the middle of byte 2 of a CLK_DIV=2 transfer.
        sel = 2;
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b0; txd = 32'h0000_77E1; txb = 3'd2; miso_mode = 2;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        repeat (39) @(negedge clk);
        check("midrst_busy_before", 32'(busy2), 32'd1);
        check("midrst_count_before", 32'(rxc2), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy2), 32'd0);
        check("midrst_done", 32'(done2), 32'd0);
        check("midrst_rxd", rxd2, 32'd0);
        check("midrst_rxc", 32'(rxc2), 32'd0);
        check("midrst_sck", 32'(sck2), 32'd0);
        check("midrst_mosi", 32'(mosi2), 32'd0);
        busy_seen = 0; done_seen = 0; sck_moves = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy2) busy_seen++;
            if (done2) done_seen++;
            if (sck2 !== 1'b0) sck_moves++;
        end
        check("midrst_no_done", 32'(done_seen), 32'd0);
        check("midrst_no_busy", 32'(busy_seen), 32'd0);
        check("midrst_sck_static", 32'(sck_moves), 32'd0);
        run_xfer("postrst", 2, 1'b0, 1'b0, 32'h0000_003C, 3'd1, 2, 32'h0000_003C, 1'b0);

        // start_i held high: one DONE, then a new transfer right after.
        run_xfer("hold", 1, 1'b0, 1'b0, 32'h0000_5AA5, 3'd2, 2, 32'h0000_5AA5, 1'b1);
        @(negedge clk);
        check("hold_restart_busy", 32'(busy1), 32'd1);
        start1 = 1'b0;
        done_k = 0;
        for (int k = 1; k <= 100; k++) begin
            if (done1) begin
                done_k = k;
                break;
            end
            @(negedge clk);
        end
        check("hold_second_done", 32'(done_k), 32'd33);
        busy_seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (busy1) busy_seen++;
        end
        check("hold_no_third", 32'(busy_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
